// File: rtl/scoreboard_multi.sv
// Multi-player pushbutton scoreboard: per-channel sync/debounce, short/long press
// classification, saturating or wrapping score counters, win detection and 7-segment digits.
module scoreboard_multi #(
  parameter int NUM_PLAYERS   = 2,
  parameter int BW            = 7,
  parameter int MAX_SCORE     = 99,
  parameter int DEBOUNCE_MS   = 20,
  parameter int LONG_PRESS_MS = 1000,
  parameter int WRAP          = 0,
  parameter int WIN_SCORE     = 0
) (
  input  logic                      clk_i,
  input  logic                      rst_n_i,
  input  logic [NUM_PLAYERS-1:0]    btn_i,
  input  logic                      clr_i,
  output logic [NUM_PLAYERS*BW-1:0] score_o,
  output logic [NUM_PLAYERS*14-1:0] seg_o,
  output logic [NUM_PLAYERS-1:0]    winner_o,
  output logic                      game_over_o
);

  localparam int DW = $clog2(DEBOUNCE_MS + 1);
  localparam int HW = $clog2(LONG_PRESS_MS + 1);

  typedef enum logic [1:0] {IDLE, HELD, WAIT_REL} state_e;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'h3F;
      4'd1:    seg7 = 7'h06;
      4'd2:    seg7 = 7'h5B;
      4'd3:    seg7 = 7'h4F;
      4'd4:    seg7 = 7'h66;
      4'd5:    seg7 = 7'h6D;
      4'd6:    seg7 = 7'h7D;
      4'd7:    seg7 = 7'h07;
      4'd8:    seg7 = 7'h7F;
      4'd9:    seg7 = 7'h6F;
      default: seg7 = 7'h00;
    endcase
  endfunction

  assign game_over_o = |winner_o;

  for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_ch
    logic          sync1_q, sync1_d, sync2_q, sync2_d;
    logic          db_q, db_d;
    logic [DW-1:0] db_cnt_q, db_cnt_d;
    state_e        state_q, state_d;
    logic [HW-1:0] hold_q, hold_d;
    logic          up_pulse, down_pulse;
    logic [BW-1:0] score_q, score_d;
    logic          win_q, win_d;
    logic [3:0]    tens, ones;
    logic [13:0]   seg_q, seg_d;

    // The debounce counter only advances while the synchronised level disagrees with the accepted one.
    always_comb begin
      sync1_d  = btn_i[p];
      sync2_d  = sync1_q;
      db_d     = db_q;
      db_cnt_d = '0;
      if (sync2_q != db_q) begin
        if (db_cnt_q == DW'(DEBOUNCE_MS - 1)) db_d = ~db_q;
        else                                  db_cnt_d = db_cnt_q + DW'(1);
      end
    end

    always_comb begin
      state_d    = state_q;
      hold_d     = hold_q;
      up_pulse   = 1'b0;
      down_pulse = 1'b0;
      case (state_q)
        IDLE: begin
          if (db_q) begin
            state_d = HELD;
            hold_d  = '0;
          end
        end
        HELD: begin
          if (!db_q) begin
            up_pulse = 1'b1;
            state_d  = IDLE;
          end else if (hold_q == HW'(LONG_PRESS_MS - 1)) begin
            down_pulse = 1'b1;
            state_d    = WAIT_REL;
          end else begin
            hold_d = hold_q + HW'(1);
          end
        end
        WAIT_REL: begin
          if (!db_q) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end

    // Winner only latches on an up-step that actually lands on the win score.
    always_comb begin
      score_d = score_q;
      win_d   = win_q;
      if (clr_i) begin
        score_d = '0;
        win_d   = 1'b0;
      end else if (!game_over_o) begin
        if (up_pulse) begin
          if (score_q == BW'(MAX_SCORE)) score_d = (WRAP != 0) ? '0 : score_q;
          else                           score_d = score_q + BW'(1);
          if (WIN_SCORE != 0 && score_d != score_q && score_d == BW'(WIN_SCORE)) win_d = 1'b1;
        end else if (down_pulse) begin
          if (score_q == '0) score_d = (WRAP != 0) ? BW'(MAX_SCORE) : score_q;
          else               score_d = score_q - BW'(1);
        end
      end
    end

    always_comb begin
      tens = 4'd0;
      ones = 4'(score_q);
      for (int t = 9; t >= 1; t--) begin
        if (tens == 4'd0 && score_q >= BW'(10 * t)) begin
          tens = 4'(t);
          ones = 4'(score_q - BW'(10 * t));
        end
      end
      seg_d = {seg7(tens), seg7(ones)};
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
        sync1_q  <= 1'b0;
        sync2_q  <= 1'b0;
        db_q     <= 1'b0;
        db_cnt_q <= '0;
        state_q  <= IDLE;
        hold_q   <= '0;
        score_q  <= '0;
        win_q    <= 1'b0;
        seg_q    <= {7'h3F, 7'h3F};
      end else begin
        sync1_q  <= sync1_d;
        sync2_q  <= sync2_d;
        db_q     <= db_d;
        db_cnt_q <= db_cnt_d;
        state_q  <= state_d;
        hold_q   <= hold_d;
        score_q  <= score_d;
        win_q    <= win_d;
        seg_q    <= seg_d;
      end
    end

    assign score_o[p*BW +: BW] = score_q;
    assign seg_o[p*14 +: 14]   = seg_q;
    assign winner_o[p]         = win_q;
  end

endmodule
